// File: rtl/rx_frame_sr.sv
// rx_frame_sr: UART receive frame assembler with a one-entry valid/ready output buffer.
// Define RX_PARITY_EN to expect a parity bit between the data field and the stop bit.
`timescale 1ns/1ps

module rx_frame_sr #(
  parameter int MAX_DATA_BITS = 8,
  parameter int MIN_DATA_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     shift_strobe,
  input  logic                     serial_in,
  input  logic [3:0]               data_size,
  input  logic                     parity_odd,
  output logic [MAX_DATA_BITS-1:0] packet_data,
  output logic                     packet_valid,
  input  logic                     packet_ready,
  output logic                     framing_error,
  output logic                     parity_error,
  output logic                     overrun_error
);

  localparam logic [3:0] MAX_SIZE = 4'(MAX_DATA_BITS);
  localparam logic [3:0] MIN_SIZE = 4'(MIN_DATA_BITS);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } state_t;
  localparam state_t AFTER_DATA = S_PAR;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd3
  } state_t;
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t                   state;
  state_t                   state_next;
  logic [3:0]               bit_count;
  logic [3:0]               size_q;
  logic [3:0]               size_clamped;
  logic [3:0]               last_bit;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic [MAX_DATA_BITS-1:0] data_just;
  logic                     stop_bit;
  logic                     frame_done;
  logic                     parity_bad;

`ifdef RX_PARITY_EN
  logic odd_q;
  logic par_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign size_clamped = (data_size < MIN_SIZE || data_size > MAX_SIZE) ? MAX_SIZE : data_size;
  assign last_bit     = size_q - 4'd1;

  // Bits enter at the MSB and move down, so a short frame is right-justified by this shift.
  assign data_just = shreg >> (MAX_SIZE - size_q);

`ifdef RX_PARITY_EN
  assign parity_bad = ((^data_just) ^ odd_q) != par_bit;
`else
  assign parity_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (frame_start) state_next = S_DATA;
      S_DATA: if (shift_strobe && bit_count == last_bit) state_next = AFTER_DATA;
`ifdef RX_PARITY_EN
      S_PAR:  if (shift_strobe) state_next = S_STOP;
`endif
      S_STOP: if (shift_strobe) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Frame assembly: frame_done marks the completion cycle that follows the stop strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count  <= '0;
      size_q     <= MAX_SIZE;
      shreg      <= '0;
      stop_bit   <= 1'b0;
      frame_done <= 1'b0;
`ifdef RX_PARITY_EN
      odd_q      <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            size_q    <= size_clamped;
            shreg     <= '0;
            bit_count <= '0;
`ifdef RX_PARITY_EN
            odd_q     <= parity_odd;
`endif
          end
        end
        S_DATA: begin
          if (shift_strobe) begin
            shreg     <= {serial_in, shreg[MAX_DATA_BITS-1:1]};
            bit_count <= bit_count + 4'd1;
          end
        end
`ifdef RX_PARITY_EN
        S_PAR: begin
          if (shift_strobe) par_bit <= serial_in;
        end
`endif
        S_STOP: begin
          if (shift_strobe) begin
            stop_bit   <= serial_in;
            frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output buffer: a completing frame may replace a held one only if it leaves this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_data   <= '0;
      packet_valid  <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (frame_done) begin
        if (!packet_valid || packet_ready) begin
          packet_data   <= data_just;
          packet_valid  <= 1'b1;
          framing_error <= ~stop_bit;
          parity_error  <= parity_bad;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (packet_valid && packet_ready) begin
        packet_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sr.sv
// Scoreboard bench for rx_frame_sr: frames are built from a frame-level model and checked on transfer.
// Honours RX_PARITY_EN the same way the design does.
`timescale 1ns/1ps

module tb_rx_frame_sr;

  localparam int MAX_BITS = 8;
  localparam int MIN_BITS = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                frame_start;
  logic                shift_strobe;
  logic                serial_in;
  logic [3:0]          data_size;
  logic                parity_odd;
  logic [MAX_BITS-1:0] packet_data;
  logic                packet_valid;
  logic                packet_ready;
  logic                framing_error;
  logic                parity_error;
  logic                overrun_error;

  typedef struct packed {
    logic [MAX_BITS-1:0] data;
    logic                fe;
    logic                pe;
  } frame_exp_t;

  frame_exp_t          exp_q[$];
  frame_exp_t          popped;
  int                  vectors = 0;
  int                  miscompares = 0;
  int                  expected_overruns = 0;
  int                  seen_overruns = 0;
  bit                  random_ready = 1'b0;
  bit                  hold_prev = 1'b0;
  frame_exp_t          hold_snap;
  int                  held = 0;

  always #5 clk = ~clk;

  rx_frame_sr #(.MAX_DATA_BITS(MAX_BITS), .MIN_DATA_BITS(MIN_BITS)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .shift_strobe(shift_strobe),
    .serial_in(serial_in), .data_size(data_size), .parity_odd(parity_odd),
    .packet_data(packet_data), .packet_valid(packet_valid), .packet_ready(packet_ready),
    .framing_error(framing_error), .parity_error(parity_error), .overrun_error(overrun_error)
  );

  function automatic int effective_size(input int field);
    if (field < MIN_BITS || field > MAX_BITS) return MAX_BITS;
    return field;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    shift_strobe = 1'b1;
    @(posedge clk); #1;
    shift_strobe = 1'b0;
    serial_in    = 1'($urandom);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_ready();
    packet_ready = 1'b1;
    @(posedge clk); #1;
    packet_ready = 1'b0;
  endtask

  // Sends one frame; the expected result comes from the frame rules, not from DUT state.
  task automatic applyStimulus(input logic [MAX_BITS-1:0] data, input int size_field, input bit odd,
                               input bit stop_val, input bit bad_par, input bit expect_drop,
                               input bit ready_at_completion, input bit check_latency);
    int n;
    frame_exp_t e;
    logic [MAX_BITS-1:0] masked;
    logic par;
    n = effective_size(size_field);
    masked = '0;
    for (int i = 0; i < n; i++) masked[i] = data[i];
    par  = (^masked) ^ odd ^ bad_par;
    e.data = masked;
    e.fe   = ~stop_val;
`ifdef RX_PARITY_EN
    e.pe   = bad_par;
`else
    e.pe   = 1'b0;
`endif
    if (expect_drop) expected_overruns++;
    else exp_q.push_back(e);

    @(posedge clk); #1;
    frame_start  = 1'b1;
    data_size    = 4'(size_field);
    parity_odd   = odd;
    shift_strobe = 1'($urandom_range(0, 1));
    serial_in    = 1'b1;
    @(posedge clk); #1;
    frame_start  = 1'b0;
    shift_strobe = 1'b0;
    data_size    = 4'($urandom);
    parity_odd   = 1'($urandom);
    for (int i = 0; i < n; i++) send_bit(data[i]);
`ifdef RX_PARITY_EN
    send_bit(par);
`endif
    serial_in    = stop_val;
    shift_strobe = 1'b1;
    @(posedge clk); #1;
    shift_strobe = 1'b0;
    if (ready_at_completion) packet_ready = 1'b1;
    if (check_latency) begin
      @(negedge clk);
      checkOutput("valid_before_latency", 32'(packet_valid), 32'd0);
    end
    @(posedge clk); #1;
    if (ready_at_completion) packet_ready = 1'b0;
    if (check_latency) checkOutput("valid_after_latency", 32'(packet_valid), 32'd1);
  endtask

  // Monitor: pops on every transfer, checks held data stays put, counts overrun cycles.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (overrun_error) seen_overruns++;
      if (hold_prev && packet_valid) begin
        checkOutput("hold_data", 32'(packet_data), 32'(hold_snap.data));
        checkOutput("hold_framing", 32'(framing_error), 32'(hold_snap.fe));
        checkOutput("hold_parity", 32'(parity_error), 32'(hold_snap.pe));
      end
      if (packet_valid && packet_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_frame: got data 0x%0h, expected no frame", packet_data);
        end else begin
          popped = exp_q.pop_front();
          checkOutput("packet_data", 32'(packet_data), 32'(popped.data));
          checkOutput("framing_error", 32'(framing_error), 32'(popped.fe));
          checkOutput("parity_error", 32'(parity_error), 32'(popped.pe));
        end
      end
      hold_prev = packet_valid && !packet_ready;
      hold_snap.data = packet_data;
      hold_snap.fe   = framing_error;
      hold_snap.pe   = parity_error;
    end
  end

  // Random consumer; forced to accept after a few stalled cycles so no frame is ever dropped.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (random_ready) begin
        if (packet_valid && held >= 3) packet_ready = 1'b1;
        else packet_ready = 1'($urandom_range(0, 1));
        if (packet_valid && !packet_ready) held++;
        else held = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int drain_cycles;
    rst = 1'b1; frame_start = 1'b0; shift_strobe = 1'b0; serial_in = 1'b1;
    data_size = 4'd8; parity_odd = 1'b0; packet_ready = 1'b0;
    #12;
    checkOutput("reset_data", 32'(packet_data), 32'd0);
    checkOutput("reset_valid", 32'(packet_valid), 32'd0);
    checkOutput("reset_framing", 32'(framing_error), 32'd0);
    checkOutput("reset_parity", 32'(parity_error), 32'd0);
    checkOutput("reset_overrun", 32'(overrun_error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] sizes");
    applyStimulus(8'hA5, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); pulse_ready();
    applyStimulus(8'hD5, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); pulse_ready();
    applyStimulus(8'hF5, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); pulse_ready();

    $display("[TB] errors");
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); pulse_ready();
    applyStimulus(8'h03, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); pulse_ready();

    $display("[TB] reset mid-frame");
    @(posedge clk); #1;
    frame_start = 1'b1; data_size = 4'd8;
    @(posedge clk); #1;
    frame_start = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #3 rst = 1'b1;
    #1;
    checkOutput("midreset_data", 32'(packet_data), 32'd0);
    checkOutput("midreset_valid", 32'(packet_valid), 32'd0);
    checkOutput("midreset_framing", 32'(framing_error), 32'd0);
    checkOutput("midreset_parity", 32'(parity_error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] clamp");
    applyStimulus(8'hC9, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); pulse_ready();
    applyStimulus(8'h9B, 12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); pulse_ready();

    $display("[TB] overrun");
    applyStimulus(8'h11, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("overrun_pulses", 32'(seen_overruns), 32'(expected_overruns));
    checkOutput("overrun_kept_data", 32'(packet_data), 32'h11);
    pulse_ready();

    $display("[TB] simultaneous accept and load");
    applyStimulus(8'h11, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("simul_no_overrun", 32'(seen_overruns), 32'(expected_overruns));
    checkOutput("simul_valid", 32'(packet_valid), 32'd1);
    pulse_ready();

    $display("[TB] random frames");
    random_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                    ($urandom_range(0, 7) != 0), 1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    random_ready = 1'b0;
    packet_ready = 1'b1;
    drain_cycles = 0;
    while (exp_q.size() != 0 && drain_cycles < 50) begin
      @(posedge clk); #1;
      drain_cycles++;
    end
    packet_ready = 1'b0;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("overrun_total", 32'(seen_overruns), 32'(expected_overruns));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
